// File: rtl/psram_spi_pkg.sv
// Shared PSRAM SPI definitions: opcodes, responder FSM states, opcode decode helper.
package psram_spi_pkg;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] CMD_WRITE     = 8'h02;
  localparam logic [7:0] CMD_READ_ID   = 8'h9F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } psram_spi_state_t;

  function automatic logic is_known_cmd(input logic [7:0] op);
    return op inside {CMD_READ, CMD_FAST_READ, CMD_WRITE, CMD_READ_ID};
  endfunction

endpackage

// File: rtl/psram_spi_sync.sv
// Synchronizes ce_n/sclk/si into clk (SYNC_STAGES >= 2) and detects sclk/ce_n edges.
module psram_spi_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic ce_n,
  input  logic sclk,
  input  logic si,
  output logic ce_n_s,
  output logic si_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ce_fall,
  output logic ce_rise
);

  logic [SYNC_STAGES-1:0] ce_sr, sclk_sr, si_sr;
  logic                   ce_q, sclk_q, sclk_s;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ce_sr   <= '1;
      sclk_sr <= '0;
      si_sr   <= '0;
      ce_q    <= 1'b1;
      sclk_q  <= 1'b0;
    end else begin
      ce_sr   <= {ce_sr[SYNC_STAGES-2:0], ce_n};
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk};
      si_sr   <= {si_sr[SYNC_STAGES-2:0], si};
      ce_q    <= ce_sr[SYNC_STAGES-1];
      sclk_q  <= sclk_sr[SYNC_STAGES-1];
    end
  end

  assign ce_n_s = ce_sr[SYNC_STAGES-1];
  assign sclk_s = sclk_sr[SYNC_STAGES-1];
  assign si_s   = si_sr[SYNC_STAGES-1];

  // sclk activity is only meaningful while the device is selected
  assign sclk_rise = sclk_s & ~sclk_q & ~ce_n_s;
  assign sclk_fall = ~sclk_s & sclk_q & ~ce_n_s;
  assign ce_fall   = ~ce_n_s & ce_q;
  assign ce_rise   = ce_n_s & ~ce_q;

endmodule

// File: rtl/psram_spi_responder.sv
// SPI PSRAM target (mode 0, MSB first) backed by a byte-wide memory array.
// Define PSRAM_PAGE_WRAP_EN to make burst addresses wrap within a PAGE_BYTES page.
module psram_spi_responder
  import psram_spi_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 12,
  parameter int unsigned DUMMY_CYCLES   = 8,
  parameter logic [7:0]  DEVICE_ID      = 8'h0D,
  parameter logic [7:0]  KGD_ID         = 8'h5D,
  parameter int unsigned PAGE_BYTES     = 1024,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ce_n,
  input  logic       sclk,
  input  logic       si,
  output logic       so,
  output logic       so_oe,
  output logic       cmd_done,
  output logic [7:0] last_cmd,
  output logic       unknown_cmd
);

  localparam int unsigned AW = MEM_ADDR_WIDTH;
`ifdef PSRAM_PAGE_WRAP_EN
  localparam bit PAGE_WRAP = 1'b1;
`else
  localparam bit PAGE_WRAP = 1'b0;
`endif
  localparam logic [AW-1:0] INC_MASK = PAGE_WRAP ? AW'(PAGE_BYTES - 1) : '1;

  // Bits under INC_MASK count; bits above it are held (all-ones mask = linear)
  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a & ~INC_MASK) | ((a + 1'b1) & INC_MASK);
  endfunction

  logic ce_n_s, si_s, sclk_rise, sclk_fall, ce_fall, ce_rise;

  psram_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .resetn    (resetn),
    .ce_n      (ce_n),
    .sclk      (sclk),
    .si        (si),
    .ce_n_s    (ce_n_s),
    .si_s      (si_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .ce_fall   (ce_fall),
    .ce_rise   (ce_rise)
  );

  psram_spi_state_t state, state_nxt;
  logic [7:0]    mem [2**AW];
  logic [7:0]    op, op_full, rd_sh, dummy_cnt;
  logic [AW-1:0] addr, addr_full, addr_next;
  logic [4:0]    bit_cnt;
  logic [6:0]    wr_sh;
  logic [2:0]    rd_cnt;
  logic          rd_primed, id_phase;
  logic          cmd_done_nxt, unknown_nxt, mem_we;

  assign op_full   = {op[6:0], si_s};
  assign addr_full = {addr[AW-2:0], si_s};
  assign addr_next = addr_inc(addr);
  assign so_oe     = (state == ST_RDATA);
  assign so        = so_oe & rd_sh[7];

  always_comb begin
    state_nxt    = state;
    cmd_done_nxt = 1'b0;
    unknown_nxt  = 1'b0;
    if (ce_rise) begin
      state_nxt    = ST_IDLE;
      cmd_done_nxt = state inside {ST_DUMMY, ST_RDATA, ST_WDATA};
    end else begin
      unique case (state)
        ST_IDLE: if (ce_fall) state_nxt = ST_CMD;
        ST_CMD: begin
          if (sclk_rise && bit_cnt == 5'd7) begin
            if (is_known_cmd(op_full)) begin
              state_nxt = ST_ADDR;
            end else begin
              state_nxt   = ST_IGNORE;
              unknown_nxt = 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (sclk_rise && bit_cnt == 5'd23) begin
            case (op)
              CMD_FAST_READ: state_nxt = ST_DUMMY;
              CMD_WRITE:     state_nxt = ST_WDATA;
              default:       state_nxt = ST_RDATA;
            endcase
          end
        end
        ST_DUMMY: if (sclk_rise && dummy_cnt == 8'(DUMMY_CYCLES - 1)) state_nxt = ST_RDATA;
        default: ;
      endcase
    end
    mem_we = resetn && !ce_n_s && (state == ST_WDATA) && sclk_rise && (bit_cnt[2:0] == 3'd7);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      op          <= '0;
      last_cmd    <= '0;
      cmd_done    <= 1'b0;
      unknown_cmd <= 1'b0;
      addr        <= '0;
      bit_cnt     <= '0;
      dummy_cnt   <= '0;
      wr_sh       <= '0;
      rd_sh       <= '0;
      rd_cnt      <= '0;
      rd_primed   <= 1'b0;
      id_phase    <= 1'b0;
    end else begin
      state       <= state_nxt;
      cmd_done    <= cmd_done_nxt;
      unknown_cmd <= unknown_nxt;
      case (state)
        ST_CMD: if (sclk_rise) begin
          op      <= op_full;
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd7 && is_known_cmd(op_full)) last_cmd <= op_full;
        end
        // First read byte is preloaded on every address bit; the last one wins
        ST_ADDR: if (sclk_rise) begin
          addr     <= addr_full;
          bit_cnt  <= bit_cnt + 5'd1;
          rd_sh    <= (op == CMD_READ_ID) ? DEVICE_ID : mem[addr_full];
          id_phase <= 1'b1;
        end
        ST_DUMMY: if (sclk_rise) dummy_cnt <= dummy_cnt + 8'd1;
        // The fall that follows the entry rise keeps the MSB on so
        ST_RDATA: if (sclk_fall) begin
          if (!rd_primed) begin
            rd_primed <= 1'b1;
          end else if (rd_cnt == 3'd7) begin
            rd_cnt <= '0;
            if (op == CMD_READ_ID) begin
              rd_sh    <= id_phase ? KGD_ID : DEVICE_ID;
              id_phase <= ~id_phase;
            end else begin
              addr  <= addr_next;
              rd_sh <= mem[addr_next];
            end
          end else begin
            rd_sh  <= {rd_sh[6:0], 1'b0};
            rd_cnt <= rd_cnt + 3'd1;
          end
        end
        ST_WDATA: if (sclk_rise) begin
          wr_sh <= {wr_sh[5:0], si_s};
          if (bit_cnt[2:0] == 3'd7) begin
            bit_cnt <= '0;
            addr    <= addr_next;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        default: ;
      endcase
      if (state_nxt != state) begin
        bit_cnt   <= '0;
        dummy_cnt <= '0;
        rd_cnt    <= '0;
        rd_primed <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= {wr_sh, si_s};
  end

endmodule

// File: tb/tb_psram_spi_responder.sv
// Self-checking bench for psram_spi_responder: command table plus hand-written corner sequences.
module tb_psram_spi_responder;
  import psram_spi_pkg::*;

  localparam logic [7:0] DEV_ID = 8'h0D;
  localparam logic [7:0] KGD    = 8'h5D;
  localparam int         HALF   = 50;

  logic       clk = 1'b0, resetn = 1'b0, ce_n = 1'b1, sclk = 1'b0, si = 1'b0;
  logic       so, so_oe, cmd_done, unknown_cmd;
  logic [7:0] last_cmd;

  always #5 clk = ~clk;

  psram_spi_responder #(.MEM_ADDR_WIDTH(12), .DUMMY_CYCLES(8)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .ce_n        (ce_n),
    .sclk        (sclk),
    .si          (si),
    .so          (so),
    .so_oe       (so_oe),
    .cmd_done    (cmd_done),
    .last_cmd    (last_cmd),
    .unknown_cmd (unknown_cmd)
  );

  typedef struct {
    logic [7:0]  op;
    logic [23:0] addr;
    int          nbytes;
    logic [15:0] wdata;
  } vec_t;

  int         n_checks = 0, n_fail = 0, done_cnt = 0, unk_cnt = 0;
  logic [7:0] model [4096];
  logic [7:0] sb_q [$];
  logic [7:0] exp_last = 8'h00;
  vec_t       vecs [8];

  always @(negedge clk) begin
    if (cmd_done) done_cnt++;
    if (unknown_cmd) unk_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] model_inc(input logic [11:0] a);
`ifdef PSRAM_PAGE_WRAP_EN
    return {a[11:10], 10'(a[9:0] + 10'd1)};
`else
    return a + 12'd1;
`endif
  endfunction

  // Mode 0 initiator: so is sampled at the end of each sclk low phase
  task automatic shift(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                       output logic oe_all, output logic oe_any);
    rx = '0; oe_all = 1'b1; oe_any = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      si = tx[7-i];
      #HALF;
      rx = {rx[6:0], so};
      oe_all &= so_oe;
      oe_any |= so_oe;
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
  endtask

  task automatic begin_cmd(input logic [7:0] op, input logic [23:0] a, output logic oe_seen);
    logic [7:0] rx;
    logic       oe_all, oe_any;
    @(negedge clk);
    ce_n = 1'b0;
    shift(op, 8, rx, oe_all, oe_seen);
    shift(a[23:16], 8, rx, oe_all, oe_any); oe_seen |= oe_any;
    shift(a[15:8],  8, rx, oe_all, oe_any); oe_seen |= oe_any;
    shift(a[7:0],   8, rx, oe_all, oe_any); oe_seen |= oe_any;
  endtask

  task automatic end_cmd();
    ce_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int          d0, u0;
    logic [11:0] ma;
    logic [7:0]  rx, b_val;
    logic        oe_all, oe_any, oe_pre, known;
    d0 = done_cnt; u0 = unk_cnt;
    known = v.op inside {CMD_READ, CMD_FAST_READ, CMD_WRITE, CMD_READ_ID};
    begin_cmd(v.op, v.addr, oe_pre);
    if (v.op == CMD_FAST_READ) begin
      shift(8'h00, 8, rx, oe_all, oe_any);
      oe_pre |= oe_any;
    end
    check("oe_low_before_data", oe_pre, 0);
    ma = v.addr[11:0];
    for (int b = 0; b < v.nbytes; b++) begin
      if (v.op == CMD_WRITE) begin
        b_val = v.wdata[15-8*b -: 8];
        shift(b_val, 8, rx, oe_all, oe_any);
        check("oe_low_write", oe_any, 0);
        model[ma] = b_val;
        ma = model_inc(ma);
      end else if (known) begin
        if (v.op == CMD_READ_ID) begin
          sb_q.push_back((b % 2) ? KGD : DEV_ID);
        end else begin
          sb_q.push_back(model[ma]);
          ma = model_inc(ma);
        end
        shift(8'h00, 8, rx, oe_all, oe_any);
        check("oe_high_read", oe_all, 1);
        check("read_byte", rx, sb_q.pop_front());
      end else begin
        shift(8'h5A, 8, rx, oe_all, oe_any);
        check("oe_low_ignore", oe_any, 0);
      end
    end
    end_cmd();
    if (known) exp_last = v.op;
    check("cmd_done_count", done_cnt - d0, {31'd0, known});
    check("unknown_count", unk_cnt - u0, {31'd0, !known});
    check("last_cmd", last_cmd, exp_last);
    check("oe_idle", so_oe, 0);
  endtask

  initial begin
    logic [7:0] rx;
    logic       oe_all, oe_any, oe_pre;
    int         d0;

    vecs[0] = '{op: CMD_WRITE,     addr: 24'h000010, nbytes: 2, wdata: 16'hA53C};
    vecs[1] = '{op: CMD_READ,      addr: 24'h000010, nbytes: 2, wdata: 16'h0000};
    vecs[2] = '{op: CMD_FAST_READ, addr: 24'h000011, nbytes: 1, wdata: 16'h0000};
    vecs[3] = '{op: CMD_READ_ID,   addr: 24'h000000, nbytes: 4, wdata: 16'h0000};
    vecs[4] = '{op: CMD_WRITE,     addr: 24'h000FFF, nbytes: 2, wdata: 16'h1122};
    vecs[5] = '{op: CMD_READ,      addr: 24'h000FFF, nbytes: 2, wdata: 16'h0000};
    vecs[6] = '{op: 8'h55,         addr: 24'h000000, nbytes: 2, wdata: 16'h0000};
    vecs[7] = '{op: CMD_READ,      addr: 24'h7F5010, nbytes: 1, wdata: 16'h0000};

    repeat (5) @(negedge clk);
    check("reset_so", so, 0);
    check("reset_so_oe", so_oe, 0);
    check("reset_cmd_done", cmd_done, 0);
    check("reset_unknown_cmd", unknown_cmd, 0);
    check("reset_last_cmd", last_cmd, 8'h00);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Partial write byte (5 bits) must leave memory untouched
    d0 = done_cnt;
    begin_cmd(CMD_WRITE, 24'h000010, oe_pre);
    shift(8'hFF, 5, rx, oe_all, oe_any);
    end_cmd();
    exp_last = CMD_WRITE;
    check("partial_write_done", done_cnt - d0, 1);
    run_vec('{op: CMD_READ, addr: 24'h000010, nbytes: 1, wdata: 16'h0000});

    // ce_n rising in the address phase: abort without cmd_done
    d0 = done_cnt;
    @(negedge clk);
    ce_n = 1'b0;
    shift(CMD_WRITE, 8, rx, oe_all, oe_any);
    shift(8'h00, 8, rx, oe_all, oe_any);
    shift(8'h00, 4, rx, oe_all, oe_any);
    end_cmd();
    exp_last = CMD_WRITE;
    check("addr_abort_no_done", done_cnt - d0, 0);
    check("addr_abort_last_cmd", last_cmd, exp_last);

    // resetn asserted in the middle of a read burst
    begin_cmd(CMD_READ, 24'h000010, oe_pre);
    shift(8'h00, 8, rx, oe_all, oe_any);
    check("pre_reset_read", rx, 8'hA5);
    shift(8'h00, 3, rx, oe_all, oe_any);
    check("pre_reset_oe", so_oe, 1);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("reset_mid_read_oe", so_oe, 0);
    check("reset_mid_read_last_cmd", last_cmd, 8'h00);
    ce_n = 1'b1;
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    exp_last = 8'h00;
    run_vec('{op: CMD_READ, addr: 24'h000011, nbytes: 1, wdata: 16'h0000});

    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/psram_spi_responder.md
Name: psram_spi_responder

Overview:
- Synthesizable SPI PSRAM target: the device end of the PSRAM SPI link, responding to command, address, dummy and data phases.
- Byte-wide internal memory array.
- Used as an on-chip stand-in for a PSRAM chip in loopback builds and as the DUT partner in controller benches.
- Oversamples the serial interface with the fabric clock. SPI mode 0, MSB first.

Parameters:
MEM_ADDR_WIDTH, 12, log2 of memory bytes; upper received address bits ignored
DUMMY_CYCLES, 8, sclk cycles between address and data for fast read
DEVICE_ID, 8'h0D, first byte returned by read-ID
KGD_ID, 8'h5D, second byte returned by read-ID
PAGE_BYTES, 1024, wrap boundary when page wrap is enabled (power of two)
SYNC_STAGES, 2, synchronizer depth on ce_n/sclk/si

Ports:
clk  in  1  fabric clock; must be >= 4x sclk
resetn  in  1  reset, synchronous, active-low
ce_n  in  1  chip enable, active-low
sclk  in  1  serial clock from initiator
si  in  1  serial data in (initiator to target)
so  out  1  serial data out (target to initiator)
so_oe  out  1  so drive enable; high only in read-data phases
cmd_done  out  1  one-cycle pulse when ce_n deasserts after a recognised command
last_cmd  out  8  opcode of most recent recognised command
unknown_cmd  out  1  one-cycle pulse when an unrecognised opcode completes

Behaviour:
- Reset values: so=0, so_oe=0, cmd_done=0, last_cmd=8'h00, unknown_cmd=0. FSM returns to IDLE and all counters are cleared. Memory contents are retained, not cleared.
- Synchronization:
  - ce_n, sclk and si each pass through SYNC_STAGES flops.
  - Rising and falling sclk edges are detected on the synchronized copy; si is sampled from the same stage.
- Commands:
  - 8'h03 read: 24-bit address, then data.
  - 8'h0B fast read: 24-bit address, DUMMY_CYCLES dummy clocks, then data.
  - 8'h02 write: 24-bit address, then data.
  - 8'h9F read-ID: 24 don't-care bits, then DEVICE_ID, KGD_ID, repeating alternately.
- FSM states: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
  - IDLE -> CMD on synchronized ce_n falling.
  - CMD: shift 8 bits on rising edges. After bit 8: 03/0B/02/9F -> ADDR, and last_cmd is updated. Any other opcode -> IGNORE with an unknown_cmd pulse.
  - ADDR: 24 bits. Then 03/9F -> RDATA, 0B -> DUMMY, 02 -> WDATA.
  - DUMMY -> RDATA after DUMMY_CYCLES rising edges.
  - RDATA: load the byte at the current address on entry. so_oe=1. so presents the MSB immediately on entry, before the first falling edge, and shifts on each subsequent falling edge. After 8 bits, the address increments and the next byte loads.
  - WDATA: collect 8 bits on rising edges. On the 8th bit, write mem[addr] in the same cycle and increment addr.
  - Any state -> IDLE on synchronized ce_n rising. so_oe drops the same cycle. cmd_done pulses if the command was recognised.
- Address arithmetic:
  - Address is addr[MEM_ADDR_WIDTH-1:0]. Increment wraps modulo 2^MEM_ADDR_WIDTH.
- Boundary conditions:
  - Partial write byte at ce_n rise is discarded; completed bytes are kept.
  - Read and write at the same address within one command cannot occur, since each command is single-direction.
  - ce_n high during a CMD or ADDR phase aborts with no memory effect and no cmd_done.
  - sclk edges while ce_n is high are ignored.
  - resetn low mid-transfer: FSM returns to IDLE; a partial byte is discarded.

Optional Feature:
- Macro: PSRAM_PAGE_WRAP_EN.
- Defined: address increment wraps within the PAGE_BYTES page. Low log2(PAGE_BYTES) bits increment; upper bits are held. Matches real device burst wrap.
- Undefined: linear increment across the full array, as in Behaviour.

Decomposition:
- Shared package psram_spi_pkg:
  - opcode constants CMD_READ=8'h03, CMD_FAST_READ=8'h0B, CMD_WRITE=8'h02, CMD_READ_ID=8'h9F
  - state enum psram_spi_state_t
  - shared by this block and the PSRAM controller.
- Sub-module psram_spi_sync: synchronizer plus sclk edge detect. Outputs ce_n_s, si_s, sclk_rise, sclk_fall, ce_fall, ce_rise.

Test Plan:
- Write 02, addr 0x000010, data A5 3C, ce_n high -> mem[0x010]=A5, mem[0x011]=3C; cmd_done pulses once; last_cmd=02.
- Read 03, addr 0x000010, 16 clocks -> so returns A5 then 3C MSB first; so_oe high only during data bits.
- Fast read 0B, addr 0x000011, 8 dummy clocks -> first data byte 3C; so_oe low during dummy.
- Read-ID 9F, 24 zero bits, 32 clocks -> so returns 0D 5D 0D 5D.
- Write at 0xFFF (MEM_ADDR_WIDTH=12), bytes 11 22 -> mem[0xFFF]=11, mem[0x000]=22. With PSRAM_PAGE_WRAP_EN: mem[0xC00]=22.
- Unknown opcode 0x55 -> unknown_cmd pulse; subsequent bits ignored; no cmd_done.
- Write 02 with 5 data bits then ce_n high -> memory unchanged.
- resetn low mid-read -> so_oe=0 the next cycle; next command decodes normally.
